// File: rtl/frac_lut6_cfg_loader_if.sv
// frac_lut6_cfg_loader_if: valid/ready word stream carrying LUT configuration frames
interface frac_lut6_cfg_loader_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_last;
  logic [15:0] cfg_data;
  modport master (output cfg_valid, cfg_data, cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, cfg_data, cfg_last, output cfg_ready);
endinterface

// File: rtl/frac_lut6_cfg_loader.sv
// frac_lut6_cfg_loader: collects 4-word frames into a shadow and commits them atomically to the LUT SRAM
module frac_lut6_cfg_loader #(
  parameter logic [63:0] INIT_VAL = 64'h0
) (
  input  logic                         prog_clk,
  input  logic                         prog_rst_n,
  frac_lut6_cfg_loader_if.slave        cfg,
  input  logic                         cfg_clear,
  output logic                         busy,
  output logic                         commit_done,
  output logic                         cfg_err,
  output logic [0:63]                  sram,
  output logic [0:63]                  sram_inv
);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ERR} state_t;
  state_t      state, state_d;
  logic [1:0]  word_cnt;
  logic [0:63] shadow;
  logic        rdy_en;
  logic        xfer;
  assign cfg.cfg_ready = rdy_en && (state == IDLE || state == LOAD);
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign busy          = state != IDLE;
  assign sram_inv      = ~sram;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = xfer ? (cfg.cfg_last ? ERR : LOAD) : IDLE;
      LOAD:    state_d = !xfer ? LOAD :
                         word_cnt == 2'd3 ? (cfg.cfg_last ? COMMIT : ERR) :
                         (cfg.cfg_last ? ERR : LOAD);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state       <= IDLE;
      rdy_en      <= 1'b0;
      word_cnt    <= 2'd0;
      shadow      <= '0;
      sram        <= INIT_VAL;
      commit_done <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_d;
      rdy_en      <= 1'b1;
      word_cnt    <= xfer ? word_cnt + 2'd1 : (state == LOAD ? word_cnt : 2'd0);
      if (xfer)
        shadow[{word_cnt, 4'b0} +: 16] <= cfg.cfg_data;
      else if (state == ERR)
        shadow <= '0;
      sram        <= state == COMMIT ? shadow :
                     (state == IDLE && cfg_clear && !xfer) ? INIT_VAL : sram;
      commit_done <= state == COMMIT;
      cfg_err     <= state == ERR;
    end
  end
endmodule

// File: tb/tb_frac_lut6_cfg_loader.sv
// tb_frac_lut6_cfg_loader: scoreboard bench for frame commit, error, stall, reset and clear behaviour
module tb_frac_lut6_cfg_loader;
  localparam logic [63:0] INIT = 64'h8000_0000_0000_0001;
  typedef struct {logic err; logic [63:0] val;} exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        busy, commit_done, cfg_err;
  logic [0:63] sram, sram_inv;
  logic [63:0] model;
  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  frac_lut6_cfg_loader_if cfg();
  frac_lut6_cfg_loader #(.INIT_VAL(INIT)) dut (
    .prog_clk(clk), .prog_rst_n(rst_n), .cfg(cfg), .cfg_clear(clear), .busy(busy),
    .commit_done(commit_done), .cfg_err(cfg_err), .sram(sram), .sram_inv(sram_inv)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (sram_inv !== ~sram) begin
        errors++;
        $display("FAIL sram_inv got=%h required=%h", sram_inv, ~sram);
      end
      if (commit_done || cfg_err) begin
        checks++;
        if (commit_done && cfg_err) begin
          errors++;
          $display("FAIL pulse_overlap commit_done=%b cfg_err=%b required not both", commit_done, cfg_err);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse commit_done=%b cfg_err=%b required none", commit_done, cfg_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.err !== cfg_err || sram !== e.val) begin
            errors++;
            $display("FAIL scoreboard err=%b sram=%h required err=%b sram=%h", cfg_err, sram, e.err, e.val);
          end
        end
      end
    end
  end
  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = d;
    cfg.cfg_last  = l;
    while (!cfg.cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cfg.cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ready=%b required 1", cfg.cfg_ready);
    end
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
    cfg.cfg_last  = 1'b0;
  endtask
  task automatic frame(input logic [63:0] v, input int last_at, input int gap_max);
    exp_t e;
    int   g;
    e.err = last_at != 3;
    e.val = last_at == 3 ? v : model;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      g = $urandom_range(0, gap_max);
      repeat (g) begin
        @(negedge clk);
        if (i > 0) begin
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_gap got=%b required=1", busy);
          end
        end
      end
      send(v[63-16*i -: 16], i == last_at);
      if (i == last_at) break;
    end
    repeat (3) @(negedge clk);
    model = e.val;
  endtask
  task automatic test_reset;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_last  = 1'b0;
    cfg.cfg_data  = 16'h0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (sram !== INIT) begin errors++; $display("FAIL reset_sram got=%h required=%h", sram, INIT); end
    if (sram_inv !== ~INIT) begin errors++; $display("FAIL reset_sram_inv got=%h required=%h", sram_inv, ~INIT); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
    if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b required=0", cfg.cfg_ready); end
    if (commit_done !== 1'b0) begin errors++; $display("FAIL reset_commit got=%b required=0", commit_done); end
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b required=0", cfg_err); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got=%b required=0", cfg.cfg_ready); end
    @(negedge clk);
    checks++;
    if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got=%b required=1", cfg.cfg_ready); end
    model = INIT;
  endtask
  task automatic test_back_to_back;
    exp_t e;
    logic [63:0] v;
    v = 64'hFFFF_0000_AAAA_5555;
    e.err = 1'b0;
    e.val = v;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) send(v[63-16*i -: 16], i == 3);
    checks += 3;
    if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL commit_ready got=%b required=0", cfg.cfg_ready); end
    if (busy !== 1'b1) begin errors++; $display("FAIL commit_busy got=%b required=1", busy); end
    if (commit_done !== 1'b0) begin errors++; $display("FAIL commit_early got=%b required=0", commit_done); end
    @(negedge clk);
    checks += 4;
    if (commit_done !== 1'b1) begin errors++; $display("FAIL commit_latency got=%b required=1", commit_done); end
    if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_commit got=%b required=1", cfg.cfg_ready); end
    if (sram !== v) begin errors++; $display("FAIL b2b_sram got=%h required=%h", sram, v); end
    if (sram_inv !== 64'h0000_FFFF_5555_AAAA) begin errors++; $display("FAIL b2b_sram_inv got=%h required=%h", sram_inv, 64'h0000_FFFF_5555_AAAA); end
    @(negedge clk);
    checks++;
    if (commit_done !== 1'b0) begin errors++; $display("FAIL commit_pulse_width got=%b required=0", commit_done); end
    repeat (2) @(negedge clk);
    model = v;
  endtask
  task automatic test_errors;
    frame(64'h1111_2222_3333_4444, 1, 0);
    frame(64'h0F0F_F0F0_1234_4321, 3, 0);
    frame(64'hDEAD_BEEF_CAFE_F00D, -1, 0);
    frame(64'h5A5A_A5A5_0000_FFFF, 0, 0);
    checks++;
    if (sram !== 64'h0F0F_F0F0_1234_4321) begin errors++; $display("FAIL sram_after_errors got=%h required=%h", sram, 64'h0F0F_F0F0_1234_4321); end
  endtask
  task automatic test_stalls;
    frame(64'hC3C3_3C3C_9669_6996, 3, 5);
    frame(64'h0123_4567_89AB_CDEF, 3, 5);
  endtask
  task automatic test_reset_mid;
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (sram !== INIT) begin errors++; $display("FAIL midreset_sram got=%h required=%h", sram, INIT); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b required=0", busy); end
    if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got=%b required=0", cfg.cfg_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model = INIT;
    frame(64'h1234_5678_9ABC_DEF0, 3, 0);
  endtask
  task automatic test_clear;
    exp_t e;
    logic [63:0] v;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks += 2;
    if (sram !== INIT) begin errors++; $display("FAIL clear_idle got=%h required=%h", sram, INIT); end
    if (commit_done !== 1'b0) begin errors++; $display("FAIL clear_commit got=%b required=0", commit_done); end
    model = INIT;
    v = 64'h7777_8888_9999_6666;
    e.err = 1'b0;
    e.val = v;
    exp_q.push_back(e);
    send(v[63:48], 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    checks += 2;
    if (sram !== model) begin errors++; $display("FAIL clear_in_load got=%h required=%h", sram, model); end
    if (busy !== 1'b1) begin errors++; $display("FAIL clear_in_load_busy got=%b required=1", busy); end
    for (int i = 1; i < 4; i++) send(v[63-16*i -: 16], i == 3);
    repeat (3) @(negedge clk);
    model = v;
    v = 64'hABCD_EF01_2345_6789;
    e.val = v;
    exp_q.push_back(e);
    clear = 1'b1;
    send(v[63:48], 1'b0);
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (sram !== model) begin errors++; $display("FAIL clear_with_xfer got=%h required=%h", sram, model); end
    for (int i = 1; i < 4; i++) send(v[63-16*i -: 16], i == 3);
    repeat (3) @(negedge clk);
    model = v;
    checks++;
    if (sram !== v) begin errors++; $display("FAIL clear_final got=%h required=%h", sram, v); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_back_to_back();
    test_errors();
    test_stalls();
    test_reset_mid();
    test_clear();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
